// File: rtl/kp_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, key field
// widths and the LFSR feedback mask.
package kp_pkg;

    localparam int KEY_W = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Taps 16,14,13,11 in right-shift form: feedback = q[0]^q[2]^q[3]^q[5]
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_RELEASE_BOUNCE,
        ST_GAP
    } kp_state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting right, new bit enters at the MSB.
// Holds its value when en is low; reset loads the seed.
module lfsr16
    import kp_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            q <= seed;
        end else if (en) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key of a row/column scanned keypad: press chatter, stable hold,
// release chatter and a quiet gap, driving active-low rows through a switch.
module keypad_emulator
    import kp_pkg::*;
#(
    parameter int          BOUNCE_LEN  = 200,
    parameter int          BOUNCE_STEP = 8,
    parameter int          GAP_LEN     = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [3:0]       columnas,
    output logic [3:0]       filas_raw,
    input  logic             req_valid,
    input  logic [KEY_W-1:0] req_key,
    input  logic [15:0]      req_hold,
    output logic             req_ready,
    output logic             busy,
    output logic             done
);

    localparam int BL_W   = $clog2(BOUNCE_LEN + 1);
    localparam int GL_W   = $clog2(GAP_LEN + 1);
    localparam int MX_W   = (BL_W > GL_W) ? BL_W : GL_W;
    localparam int CNT_W  = (MX_W > 16) ? MX_W : 16;
    localparam int STEP_W = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

    kp_state_e          state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, phase_len;
    logic [STEP_W-1:0]  step, step_nx;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [15:0]        hold_q;
    logic               armed;
    logic               phase_last;
    logic               bounce;
    logic               lfsr_en;
    logic [15:0]        lfsr_q;
    logic               contact;
    logic               unused_lfsr;

    assign unused_lfsr = ^lfsr_q[15:1];

    assign bounce     = (state == ST_PRESS_BOUNCE) || (state == ST_RELEASE_BOUNCE);
    assign lfsr_en    = bounce && (step == STEP_W'(BOUNCE_STEP - 1));
    assign phase_last = (cnt == phase_len - CNT_W'(1));
    assign req_ready  = armed && (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_GAP) && phase_last;

    lfsr16 u_lfsr (
        .clk     (clk),
        .n_reset (n_reset),
        .en      (lfsr_en),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    always_comb begin
        phase_len = CNT_W'(1);
        case (state)
            ST_PRESS_BOUNCE,
            ST_RELEASE_BOUNCE: phase_len = CNT_W'(BOUNCE_LEN);
            ST_HOLD:           phase_len = CNT_W'(hold_q);
            ST_GAP:            phase_len = CNT_W'(GAP_LEN);
            default:           phase_len = CNT_W'(1);
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step_nx  = step;
        if (state == ST_IDLE) begin
            cnt_nx  = '0;
            step_nx = '0;
            if (req_valid && req_ready) state_nx = ST_PRESS_BOUNCE;
        end else if (phase_last) begin
            cnt_nx  = '0;
            step_nx = '0;
            case (state)
                ST_PRESS_BOUNCE:   state_nx = ST_HOLD;
                ST_HOLD:           state_nx = ST_RELEASE_BOUNCE;
                ST_RELEASE_BOUNCE: state_nx = ST_GAP;
                default:           state_nx = ST_IDLE;
            endcase
        end else begin
            cnt_nx  = cnt + CNT_W'(1);
            step_nx = (step == STEP_W'(BOUNCE_STEP - 1)) ? '0 : step + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            step   <= '0;
            row_q  <= '0;
            col_q  <= '0;
            hold_q <= '0;
            armed  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            step  <= step_nx;
            armed <= 1'b1;
            if (req_valid && req_ready) begin
                row_q  <= req_key[3:2];
                col_q  <= req_key[1:0];
                hold_q <= (req_hold == 16'd0) ? 16'd1 : req_hold;
            end
        end
    end

    // Contact follows state directly so an async reset opens it at once.
    always_comb begin
        contact = 1'b0;
        case (state)
            ST_HOLD:           contact = 1'b1;
            ST_PRESS_BOUNCE:   contact = phase_last ? 1'b1 : lfsr_q[0];
            ST_RELEASE_BOUNCE: contact = phase_last ? 1'b0 : lfsr_q[0];
            default:           contact = 1'b0;
        endcase
    end

    always_comb begin
        filas_raw = '1;
        if (contact && !columnas[col_q]) filas_raw[row_q] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: default instance plus a short-bounce
// instance used for chatter-pattern and hold-length boundary checks.
module tb_keypad_emulator;

    logic        clk;
    logic        n_reset;
    logic [3:0]  columnas_a, filas_a, req_key_a;
    logic [15:0] req_hold_a;
    logic        req_valid_a, ready_a, busy_a, done_a;
    logic [3:0]  columnas_b, filas_b, req_key_b;
    logic [15:0] req_hold_b;
    logic        req_valid_b, ready_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;
    int idx, cnt, bad, bad2, trans, mtrans;
    logic [15:0] m;
    logic expc, obsc, prevc, mprevc;

    keypad_emulator dut_a (
        .clk(clk), .n_reset(n_reset), .columnas(columnas_a), .filas_raw(filas_a),
        .req_valid(req_valid_a), .req_key(req_key_a), .req_hold(req_hold_a),
        .req_ready(ready_a), .busy(busy_a), .done(done_a)
    );

    keypad_emulator #(.BOUNCE_LEN(64), .BOUNCE_STEP(8), .GAP_LEN(16), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .n_reset(n_reset), .columnas(columnas_b), .filas_raw(filas_b),
        .req_valid(req_valid_b), .req_key(req_key_b), .req_hold(req_hold_b),
        .req_ready(ready_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req_b(input logic [15:0] hold, input int limit, output int d_idx, output int d_cnt);
        req_key_b   = 4'b0110;
        req_hold_b  = hold;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        d_idx = -1;
        d_cnt = 0;
        for (int k = 0; k < limit; k++) begin
            if (done_b) begin
                d_cnt++;
                if (d_idx < 0) d_idx = k;
            end
            tick();
        end
    endtask

    initial begin
        n_reset = 1'b0;
        columnas_a = 4'b0000; req_valid_a = 1'b0; req_key_a = '0; req_hold_a = '0;
        columnas_b = 4'b1111; req_valid_b = 1'b0; req_key_b = '0; req_hold_b = '0;

        // Reset state
        tick(); tick();
        chk("rst_filas_a", filas_a, 4'b1111);
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_filas_b", filas_b, 4'b1111);
        n_reset = 1'b1;
        #1;
        chk("ready_before_edge", ready_a, 1'b0);
        tick();
        chk("ready_first_edge", ready_a, 1'b1);

        // Column scan with no request
        for (int p = 0; p < 4; p++) begin
            columnas_a = 4'(~(4'b0001 << p));
            for (int r = 0; r < 3; r++) begin
                tick();
                chk("idle_filas", filas_a, 4'b1111);
                chk("idle_ready", ready_a, 1'b1);
                chk("idle_busy", busy_a, 1'b0);
            end
        end

        // Press chatter against reference LFSR
        columnas_b  = 4'b1011;
        req_key_b   = 4'b0110;
        req_hold_b  = 16'd5;
        chk("b_ready", ready_b, 1'b1);
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        m = 16'hACE1; prevc = 1'b0; mprevc = 1'b0; trans = 0; mtrans = 0;
        for (int i = 0; i < 64; i++) begin
            expc = (i == 63) ? 1'b1 : m[0];
            obsc = ~filas_b[1];
            chk("b_press_filas", filas_b, expc ? 4'b1101 : 4'b1111);
            if (obsc != prevc) trans++;
            if (expc != mprevc) mtrans++;
            prevc = obsc; mprevc = expc;
            if (i % 8 == 7) m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
            tick();
        end
        chk("b_trans_le8", 32'(trans <= 8), 1);
        chk("b_trans_model", trans, mtrans);
        idx = -1; cnt = 0; bad = 0;
        for (int k = 64; k < 300; k++) begin
            if (k < 69 && filas_b !== 4'b1101) bad++;
            if (done_b) begin
                cnt++;
                if (idx < 0) idx = k;
            end
            tick();
        end
        chk("b_hold_filas", bad, 0);
        chk("b_done_idx", idx, 148);
        chk("b_done_cnt", cnt, 1);

        // Hold 0 behaves as 1; hold FFFF gives full 65535 cycles
        req_b(16'd0, 300, idx, cnt);
        chk("b_hold0_idx", idx, 144);
        chk("b_hold0_cnt", cnt, 1);
        req_b(16'hFFFF, 65800, idx, cnt);
        chk("b_holdmax_idx", idx, 65678);
        chk("b_holdmax_cnt", cnt, 1);
        chk("b_ready_after", ready_b, 1'b1);

        // Main request plus ignored request during HOLD
        columnas_a = 4'b1011; req_key_a = 4'b0110; req_hold_a = 16'd1000;
        req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        idx = -1; cnt = 0; bad = 0; bad2 = 0;
        for (int k = 0; k < 1600; k++) begin
            if (done_a) begin
                cnt++;
                if (idx < 0) idx = k;
            end
            if (k >= 200 && k < 1200 && filas_a !== 4'b1101) bad++;
            if (k >= 1400 && filas_a !== 4'b1111) bad2++;
            if (k == 500) begin
                req_valid_a = 1'b1; req_key_a = 4'b0001; req_hold_a = 16'd3;
                chk("hold_ready", ready_a, 1'b0);
                chk("hold_busy", busy_a, 1'b1);
            end
            if (k == 503) req_valid_a = 1'b0;
            tick();
        end
        chk("a_hold_filas", bad, 0);
        chk("a_after_filas", bad2, 0);
        chk("a_done_idx", idx, 1499);
        chk("a_done_cnt", cnt, 1);
        chk("a_ready_end", ready_a, 1'b1);

        // Unselected column: rows never assert
        columnas_a = 4'b1110; req_key_a = 4'b0110; req_hold_a = 16'd1000;
        req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        idx = -1; cnt = 0; bad = 0;
        for (int k = 0; k < 1600; k++) begin
            if (done_a) begin
                cnt++;
                if (idx < 0) idx = k;
            end
            if (filas_a !== 4'b1111) bad++;
            tick();
        end
        chk("wrongcol_filas", bad, 0);
        chk("wrongcol_done_cnt", cnt, 1);
        chk("wrongcol_done_idx", idx, 1499);

        // Reset during HOLD
        columnas_a = 4'b1011;
        req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        for (int k = 0; k < 300; k++) tick();
        chk("rstmid_hold_filas", filas_a, 4'b1101);
        n_reset = 1'b0;
        #1;
        chk("rstmid_filas", filas_a, 4'b1111);
        chk("rstmid_busy", busy_a, 1'b0);
        chk("rstmid_ready", ready_a, 1'b0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (done_a) cnt++;
            tick();
        end
        n_reset = 1'b1;
        tick();
        chk("rstmid_ready_after", ready_a, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (done_a) cnt++;
            tick();
        end
        chk("rstmid_no_done", cnt, 0);
        req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        chk("rstmid_new_busy", busy_a, 1'b1);
        chk("rstmid_new_ready", ready_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
